// File: rtl/fe_capture_sequencer_pkg.sv
// Shared encodings for the front-end capture sequencer: FSM states and the
// completion status codes reported to the register block.
package fe_capture_sequencer_pkg;

    typedef enum logic [2:0] {
        FE_SEQ_S_IDLE    = 3'd0,
        FE_SEQ_S_FLUSH   = 3'd1,
        FE_SEQ_S_SETTLE  = 3'd2,
        FE_SEQ_S_ARMED   = 3'd3,
        FE_SEQ_S_CAPTURE = 3'd4,
        FE_SEQ_S_DONE    = 3'd5
    } fe_seq_state_e;

    localparam logic [1:0] FE_SEQ_STAT_NONE    = 2'd0;
    localparam logic [1:0] FE_SEQ_STAT_OK      = 2'd1;
    localparam logic [1:0] FE_SEQ_STAT_TIMEOUT = 2'd2;
    localparam logic [1:0] FE_SEQ_STAT_ABORT   = 2'd3;

    // The front end sees arm asserted while waiting for and during a capture.
    function automatic logic arms_frontend(input fe_seq_state_e s);
        return (s == FE_SEQ_S_ARMED) || (s == FE_SEQ_S_CAPTURE);
    endfunction

    // States in which an abort strobe terminates the sequence.
    function automatic logic abortable(input fe_seq_state_e s);
        return (s == FE_SEQ_S_FLUSH) || (s == FE_SEQ_S_SETTLE) ||
               (s == FE_SEQ_S_ARMED) || (s == FE_SEQ_S_CAPTURE);
    endfunction

endpackage

// File: rtl/fe_seq_timer.sv
// Loadable counter with zero-detect and compare-equal; counts up or down
// depending on pCOUNT_DOWN. Load takes priority over enable.
module fe_seq_timer #(
    parameter int pWIDTH      = 8,
    parameter bit pCOUNT_DOWN = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [pWIDTH-1:0] load_val_i,
    input  logic              en_i,
    input  logic [pWIDTH-1:0] cmp_val_i,
    output logic              zero_o,
    output logic              eq_o
);

    logic [pWIDTH-1:0] count_q;
    logic [pWIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            if (pCOUNT_DOWN) begin
                count_d = count_q - pWIDTH'(1);
            end else begin
                count_d = count_q + pWIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);
    assign eq_o   = (count_q == cmp_val_i);

endmodule

// File: rtl/fe_capture_sequencer.sv
// Sequences one front-end capture: flush FIFO, settle, arm, wait for capture
// start and end, then pulse done with a status code.
module fe_capture_sequencer
    import fe_capture_sequencer_pkg::*;
#(
    parameter int pTIMEOUT_WIDTH = 24,
    parameter int pSETTLE_WIDTH  = 8,
    parameter int pCOUNT_WIDTH   = 8
) (
    input  logic                      cwusb_clk,
    input  logic                      reset_n,
    input  logic                      I_arm_req,
    input  logic                      I_abort,
    input  logic [pSETTLE_WIDTH-1:0]  I_settle_cycles,
    input  logic [pTIMEOUT_WIDTH-1:0] I_timeout_cycles,
    input  logic                      I_fifo_empty,
    input  logic                      I_capturing,
    output logic                      O_fifo_flush,
    output logic                      O_arm,
    output logic                      O_reg_arm,
    output logic                      O_busy,
    output logic                      O_done,
    output logic [1:0]                O_status,
    output logic [pCOUNT_WIDTH-1:0]   O_capture_count,
    output logic [2:0]                O_dbg_state
);

    fe_seq_state_e             state_q, state_d;
    logic [1:0]                status_q, status_d;
    logic                      flush_q, arm_q, reg_arm_q, busy_q, done_q;
    logic [pCOUNT_WIDTH-1:0]   count_q;

    logic                      settle_load, settle_en, settle_zero, settle_eq;
    logic                      tmo_load, tmo_en, tmo_zero, tmo_eq;
    logic                      timeout_hit;
    logic [pTIMEOUT_WIDTH-1:0] tmo_last;
    logic                      unused_timer_flags;

    // Both timers reload on the edge that enters their state.
    assign settle_load = (state_d == FE_SEQ_S_SETTLE) && (state_q != FE_SEQ_S_SETTLE);
    assign settle_en   = (state_q == FE_SEQ_S_SETTLE);
    assign tmo_load    = (state_d == FE_SEQ_S_ARMED) && (state_q != FE_SEQ_S_ARMED);
    assign tmo_en      = (state_q == FE_SEQ_S_ARMED);
    assign tmo_last    = I_timeout_cycles - pTIMEOUT_WIDTH'(1);
    assign timeout_hit = (I_timeout_cycles != '0) && tmo_eq;

    fe_seq_timer #(
        .pWIDTH      (pSETTLE_WIDTH),
        .pCOUNT_DOWN (1'b1)
    ) u_settle_timer (
        .clk_i      (cwusb_clk),
        .rst_ni     (reset_n),
        .load_i     (settle_load),
        .load_val_i (I_settle_cycles),
        .en_i       (settle_en),
        .cmp_val_i  ('0),
        .zero_o     (settle_zero),
        .eq_o       (settle_eq)
    );

    fe_seq_timer #(
        .pWIDTH      (pTIMEOUT_WIDTH),
        .pCOUNT_DOWN (1'b0)
    ) u_timeout_timer (
        .clk_i      (cwusb_clk),
        .rst_ni     (reset_n),
        .load_i     (tmo_load),
        .load_val_i ('0),
        .en_i       (tmo_en),
        .cmp_val_i  (tmo_last),
        .zero_o     (tmo_zero),
        .eq_o       (tmo_eq)
    );

    assign unused_timer_flags = settle_eq ^ tmo_zero;

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        if (abortable(state_q) && I_abort) begin
            state_d  = FE_SEQ_S_DONE;
            status_d = FE_SEQ_STAT_ABORT;
        end else begin
            case (state_q)
                FE_SEQ_S_IDLE: begin
                    // Abort arriving with the arm strobe cancels it outright.
                    if (I_arm_req && !I_abort) begin
                        status_d = FE_SEQ_STAT_NONE;
                        state_d  = I_fifo_empty ? FE_SEQ_S_SETTLE : FE_SEQ_S_FLUSH;
                    end
                end
                FE_SEQ_S_FLUSH: begin
                    if (I_fifo_empty) begin
                        state_d = FE_SEQ_S_SETTLE;
                    end
                end
                FE_SEQ_S_SETTLE: begin
                    if (settle_zero) begin
                        state_d = FE_SEQ_S_ARMED;
                    end
                end
                FE_SEQ_S_ARMED: begin
                    if (I_capturing) begin
                        state_d = FE_SEQ_S_CAPTURE;
                    end else if (timeout_hit) begin
                        state_d  = FE_SEQ_S_DONE;
                        status_d = FE_SEQ_STAT_TIMEOUT;
                    end
                end
                FE_SEQ_S_CAPTURE: begin
                    if (!I_capturing) begin
                        state_d  = FE_SEQ_S_DONE;
                        status_d = FE_SEQ_STAT_OK;
                    end
                end
                FE_SEQ_S_DONE: begin
                    state_d = FE_SEQ_S_IDLE;
                end
                default: begin
                    state_d = FE_SEQ_S_IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge cwusb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FE_SEQ_S_IDLE;
            status_q  <= FE_SEQ_STAT_NONE;
            flush_q   <= 1'b0;
            arm_q     <= 1'b0;
            reg_arm_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            flush_q   <= (state_d == FE_SEQ_S_FLUSH);
            arm_q     <= arms_frontend(state_d);
            reg_arm_q <= (state_d == FE_SEQ_S_ARMED);
            busy_q    <= (state_d != FE_SEQ_S_IDLE);
            done_q    <= (state_d == FE_SEQ_S_DONE);
            if ((state_d == FE_SEQ_S_DONE) && (state_q != FE_SEQ_S_DONE) &&
                (status_d == FE_SEQ_STAT_OK) && (count_q != '1)) begin
                count_q <= count_q + pCOUNT_WIDTH'(1);
            end
        end
    end

    assign O_fifo_flush    = flush_q;
    assign O_arm           = arm_q;
    assign O_reg_arm       = reg_arm_q;
    assign O_busy          = busy_q;
    assign O_done          = done_q;
    assign O_status        = status_q;
    assign O_capture_count = count_q;
    assign O_dbg_state     = state_q;

endmodule

// File: tb/tb_fe_capture_sequencer.sv
// Bench for fe_capture_sequencer: table of directed transactions, IDLE corner
// sequences, async reset mid-flush, randomized transactions, count saturation.
module tb_fe_capture_sequencer;

    localparam int W = 15;

    logic        cwusb_clk;
    logic        reset_n;
    logic        I_arm_req;
    logic        I_abort;
    logic [7:0]  I_settle_cycles;
    logic [23:0] I_timeout_cycles;
    logic        I_fifo_empty;
    logic        I_capturing;
    logic        O_fifo_flush;
    logic        O_arm;
    logic        O_reg_arm;
    logic        O_busy;
    logic        O_done;
    logic [1:0]  O_status;
    logic [7:0]  O_capture_count;
    logic [2:0]  O_dbg_state;

    int checks;
    int errors;
    int m_count;
    int m_status;
    logic [W-1:0] exp_q[$];

    typedef struct {
        bit e0;
        int f;
        int s;
        int t;
        int d;
        int l;
        int x;
        int stray;
        int exp_status;
        int exp_rise;
        int exp_len;
        int exp_done;
    } vec_t;

    vec_t tbl[10];

    fe_capture_sequencer dut (
        .cwusb_clk        (cwusb_clk),
        .reset_n          (reset_n),
        .I_arm_req        (I_arm_req),
        .I_abort          (I_abort),
        .I_settle_cycles  (I_settle_cycles),
        .I_timeout_cycles (I_timeout_cycles),
        .I_fifo_empty     (I_fifo_empty),
        .I_capturing      (I_capturing),
        .O_fifo_flush     (O_fifo_flush),
        .O_arm            (O_arm),
        .O_reg_arm        (O_reg_arm),
        .O_busy           (O_busy),
        .O_done           (O_done),
        .O_status         (O_status),
        .O_capture_count  (O_capture_count),
        .O_dbg_state      (O_dbg_state)
    );

    // Clock and reset
    initial cwusb_clk = 1'b0;
    always #5 cwusb_clk = ~cwusb_clk;

    function automatic logic [W-1:0] pack_exp(input bit fl, input bit ar, input bit ra,
                                              input bit bs, input bit dn, input int st,
                                              input int cn);
        logic [1:0] s2;
        logic [7:0] c8;
        s2 = st[1:0];
        c8 = cn[7:0];
        return {fl, ar, ra, bs, dn, s2, c8};
    endfunction

    function automatic logic [W-1:0] got_vec();
        return {O_fifo_flush, O_arm, O_reg_arm, O_busy, O_done, O_status, O_capture_count};
    endfunction

    task automatic check_vec(input string name, input int k, input logic [W-1:0] got,
                             input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got{flush,arm,reg_arm,busy,done,status,count}=%b_%b_%b_%b_%b_%0d_%0d required=%b_%b_%b_%b_%b_%0d_%0d",
                     name, k, got[14], got[13], got[12], got[11], got[10], got[9:8], got[7:0],
                     exp[14], exp[13], exp[12], exp[11], exp[10], exp[9:8], exp[7:0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    // Driver + model: one arm strobe at cycle 0 (relative). The expected
    // timeline is laid out as cycle intervals: flush 1..f, settle for s+1
    // cycles, arm from a, capture window, done, then idle.
    task automatic run_txn(input string name, input bit e0, input int f, input int s,
                           input int t, input int d, input int l, input int x,
                           input int stray, output int obs_rise, output int obs_len,
                           output int obs_done, output int obs_status);
        int flen, a, done_c, fin, cap_c, nxt_cnt, st, cn;
        bit use_abort;
        logic [W-1:0] exp;
        flen = e0 ? 0 : f;
        a = flen + s + 2;
        if (t != 0 && d >= t) begin
            done_c = a + t;
            fin = 2;
        end else begin
            done_c = a + d + l + 1;
            fin = 1;
        end
        use_abort = (x > 0) && (x < done_c);
        if (use_abort) begin
            done_c = x + 1;
            fin = 3;
        end
        cap_c = a + d + 1;
        nxt_cnt = (fin == 1) ? ((m_count >= 255) ? 255 : m_count + 1) : m_count;
        for (int k = 0; k <= done_c + 1; k++) begin
            st = (k == 0) ? m_status : ((k < done_c) ? 0 : fin);
            cn = (k >= done_c) ? nxt_cnt : m_count;
            exp_q.push_back(pack_exp(k >= 1 && k <= flen && k < done_c,
                                     k >= a && k < done_c,
                                     k >= a && k < done_c && k < cap_c,
                                     k >= 1 && k <= done_c,
                                     k == done_c, st, cn));
        end
        I_settle_cycles  = s[7:0];
        I_timeout_cycles = t[23:0];
        obs_rise = -1;
        obs_len = 0;
        obs_done = -1;
        obs_status = -1;
        for (int k = 0; k <= done_c + 1; k++) begin
            I_arm_req    = (k == 0) || (stray > 0 && k == stray && k <= done_c);
            I_abort      = use_abort && (k == x);
            I_fifo_empty = e0 || (k >= f);
            I_capturing  = (k >= a + d) && (k < a + d + l);
            @(negedge cwusb_clk);
            exp = exp_q.pop_front();
            check_vec(name, k, got_vec(), exp);
            if (O_arm) begin
                if (obs_rise < 0) obs_rise = k;
                obs_len++;
            end
            if (O_done) begin
                obs_done = k;
                obs_status = int'(O_status);
            end
            @(posedge cwusb_clk);
            #1;
        end
        I_arm_req = 1'b0;
        I_abort = 1'b0;
        I_capturing = 1'b0;
        m_status = fin;
        m_count = nxt_cnt;
    endtask

    task automatic idle_cycles(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge cwusb_clk);
            check_vec(name, k, got_vec(), pack_exp(0, 0, 0, 0, 0, m_status, m_count));
            I_arm_req = 1'b0;
            I_abort = 1'b0;
            @(posedge cwusb_clk);
            #1;
        end
    endtask

    initial begin
        int rise, len, dn, sts;
        int e0, f, s, t, d, l, x, stray;
        checks = 0;
        errors = 0;
        m_count = 0;
        m_status = 0;

        tbl[0] = '{1, 0, 3, 0,   10,  20, 0, 6,  1, 5, 31, 36};
        tbl[1] = '{0, 7, 0, 0,   0,   3,  0, 0,  1, 9, 4,  13};
        tbl[2] = '{1, 0, 0, 100, 200, 1,  0, 50, 2, 2, 100, 102};
        tbl[3] = '{1, 0, 1, 0,   2,   10, 7, 0,  3, 3, 5,  8};
        tbl[4] = '{0, 6, 2, 0,   0,   1,  3, 2,  3, -1, 0, 4};
        tbl[5] = '{1, 0, 0, 5,   4,   2,  0, 0,  1, 2, 7,  9};
        tbl[6] = '{1, 0, 0, 5,   5,   2,  0, 0,  2, 2, 5,  7};
        tbl[7] = '{1, 0, 5, 0,   1,   1,  2, 0,  3, -1, 0, 3};
        tbl[8] = '{1, 0, 0, 0,   5,   2,  4, 0,  3, 2, 3,  5};
        tbl[9] = '{1, 0, 2, 1,   3,   1,  0, 0,  2, 4, 1,  5};

        reset_n = 1'b0;
        I_arm_req = 1'b0;
        I_abort = 1'b0;
        I_settle_cycles = '0;
        I_timeout_cycles = '0;
        I_fifo_empty = 1'b0;
        I_capturing = 1'b0;
        repeat (3) @(posedge cwusb_clk);
        #1;
        check_vec("reset", 0, got_vec(), pack_exp(0, 0, 0, 0, 0, 0, 0));
        reset_n = 1'b1;
        @(posedge cwusb_clk);
        #1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_txn($sformatf("tbl%0d", i), tbl[i].e0, tbl[i].f, tbl[i].s, tbl[i].t,
                    tbl[i].d, tbl[i].l, tbl[i].x, tbl[i].stray, rise, len, dn, sts);
            check_int($sformatf("tbl%0d_arm_rise", i), rise, tbl[i].exp_rise);
            check_int($sformatf("tbl%0d_arm_len", i), len, tbl[i].exp_len);
            check_int($sformatf("tbl%0d_done_cyc", i), dn, tbl[i].exp_done);
            check_int($sformatf("tbl%0d_status", i), sts, tbl[i].exp_status);
        end

        // Arm and abort together in IDLE: nothing happens, status 2 kept
        I_arm_req = 1'b1;
        I_abort = 1'b1;
        I_fifo_empty = 1'b1;
        idle_cycles("arm_abort_idle", 4);
        I_abort = 1'b1;
        idle_cycles("abort_idle", 2);

        // Asynchronous reset in the middle of a flush
        I_fifo_empty = 1'b0;
        I_arm_req = 1'b1;
        @(posedge cwusb_clk);
        #1;
        I_arm_req = 1'b0;
        repeat (2) @(posedge cwusb_clk);
        #1;
        check_vec("pre_async_rst", 0, got_vec(), pack_exp(1, 0, 0, 1, 0, 0, m_count));
        #2;
        reset_n = 1'b0;
        #1;
        check_vec("async_rst", 0, got_vec(), pack_exp(0, 0, 0, 0, 0, 0, 0));
        @(posedge cwusb_clk);
        #1;
        reset_n = 1'b1;
        m_count = 0;
        m_status = 0;
        run_txn("post_rst", 1, 0, 2, 0, 1, 2, 0, 0, rise, len, dn, sts);
        check_int("post_rst_status", sts, 1);

        // Randomized transactions against the interval model
        for (int i = 0; i < 40; i++) begin
            e0 = $urandom_range(0, 1);
            f = $urandom_range(1, 10);
            s = $urandom_range(0, 6);
            t = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12));
            d = $urandom_range(0, 15);
            l = $urandom_range(1, 6);
            x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0;
            stray = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 45)) : 0;
            run_txn($sformatf("rnd%0d", i), e0[0], f, s, t, d, l, x, stray, rise, len, dn, sts);
        end

        // Capture counter saturation: fresh count after the reset above
        while (m_count < 255) begin
            run_txn("sat", 1, 0, 0, 0, 0, 1, 0, 0, rise, len, dn, sts);
        end
        run_txn("sat_over1", 1, 0, 0, 0, 0, 1, 0, 0, rise, len, dn, sts);
        run_txn("sat_over2", 1, 0, 0, 0, 0, 1, 0, 0, rise, len, dn, sts);
        @(negedge cwusb_clk);
        check_int("sat_count", int'(O_capture_count), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
